// File: rtl/uart_mouse_tracker.sv
// Mouse packet receiver: decodes SYNC-framed packets from the UART RX byte stream into a clamped cursor.
// Build option: define MOUSE_CHECKSUM_EN to expect a 7th XOR checksum byte after the buttons byte.
module uart_mouse_tracker #(
  parameter int unsigned FREQ_HZ     = 27000000,
  parameter int unsigned TIMEOUT_US  = 2000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned POS_W       = 11,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned DELTA_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_avail,
  output logic             rx_ack,
  input  logic             center,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       buttons,
  output logic [2:0]       btn_press,
  output logic [2:0]       btn_release,
  output logic             pkt_valid,
  output logic             pkt_error,
  output logic [15:0]      pkt_count
);

  localparam int unsigned TMO_LIMIT = FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam int unsigned SW        = POS_W + 5;

  localparam logic [POS_W-1:0]     X_RST   = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0]     Y_RST   = POS_W'(Y_MAX / 2);
  localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_XL    = 3'd1,
    ST_XH    = 3'd2,
    ST_YL    = 3'd3,
    ST_YH    = 3'd4,
    ST_BTN   = 3'd5,
    ST_CHK   = 3'd6,
    ST_APPLY = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic [7:0]       byte_q, byte_d;
  logic             rx_ack_q, rx_ack_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       xl_q, xl_d, yl_q, yl_d;
  logic             xh_q, xh_d, yh_q, yh_d;
  logic [2:0]       btn_q, btn_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [2:0]       buttons_q, buttons_d;
  logic [2:0]       btn_press_q, btn_press_d;
  logic [2:0]       btn_release_q, btn_release_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_error_q, pkt_error_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic                 take_s;
  logic                 tmo_hit_s;
  logic                 tmo_s;
  logic                 frame_err_s;
  logic                 sum_err_s;
  logic signed [SW-1:0] dx_s, dy_s, nx_s, ny_s;

  function automatic logic [POS_W-1:0] clamp_pos(input logic signed [SW-1:0] v,
                                                 input logic signed [SW-1:0] vmax);
    logic [POS_W-1:0] r;
    if (v[SW-1]) begin
      r = {POS_W{1'b0}};
    end else if (v > vmax) begin
      r = vmax[POS_W-1:0];
    end else begin
      r = v[POS_W-1:0];
    end
    return r;
  endfunction

`ifdef MOUSE_CHECKSUM_EN
  // XH/YH/BTN were framing-checked, so their upper bits are known zero.
  function automatic logic [7:0] pkt_checksum(input logic [7:0] xl, input logic xh,
                                              input logic [7:0] yl, input logic yh,
                                              input logic [2:0] btn);
    return xl ^ {7'd0, xh} ^ yl ^ {7'd0, yh} ^ {5'd0, btn};
  endfunction
`endif

  assign rx_ack      = rx_ack_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign buttons     = buttons_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign pkt_valid   = pkt_valid_q;
  assign pkt_error   = pkt_error_q;
  assign pkt_count   = pkt_count_q;

  // Handshake: latch the byte when offered outside an ack cycle; it is decoded during the ack cycle.
  always_comb begin
    take_s   = rx_avail & ~rx_ack_q;
    rx_ack_d = take_s;
    if (take_s) begin
      byte_d = rx_data;
    end else begin
      byte_d = byte_q;
    end
    if ((state_q == ST_SYNC) || rx_ack_q) begin
      tmo_d = {TMO_W{1'b0}};
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
    tmo_hit_s = (tmo_q == TMO_W'(TMO_LIMIT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a decoded byte always takes priority over the inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    tmo_s       = 1'b0;
    frame_err_s = 1'b0;
    sum_err_s   = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (rx_ack_q && (byte_q == SYNC_BYTE)) begin
          state_d = ST_XL;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_XL, ST_YL: begin
        if (rx_ack_q) begin
          state_d = (state_q == ST_XL) ? ST_XH : ST_YH;
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          state_d = state_q;
        end
      end
      ST_XH, ST_YH: begin
        if (rx_ack_q) begin
          if (byte_q[7:1] != 7'd0) begin
            frame_err_s = 1'b1;
            state_d     = ST_SYNC;
          end else begin
            state_d = (state_q == ST_XH) ? ST_YL : ST_BTN;
          end
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          state_d = state_q;
        end
      end
      ST_BTN: begin
        if (rx_ack_q) begin
          if (byte_q[7:3] != 5'd0) begin
            frame_err_s = 1'b1;
            state_d     = ST_SYNC;
          end else begin
`ifdef MOUSE_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_APPLY;
`endif
          end
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          state_d = ST_BTN;
        end
      end
`ifdef MOUSE_CHECKSUM_EN
      ST_CHK: begin
        if (rx_ack_q) begin
          if (byte_q != pkt_checksum(xl_q, xh_q, yl_q, yh_q, btn_q)) begin
            sum_err_s = 1'b1;
            state_d   = ST_SYNC;
          end else begin
            state_d = ST_APPLY;
          end
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_d = ST_SYNC;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      ST_APPLY: state_d = ST_SYNC;
      default:  state_d = ST_SYNC;
    endcase
  end

  // Field capture from decoded bytes.
  always_comb begin
    xl_d  = xl_q;
    xh_d  = xh_q;
    yl_d  = yl_q;
    yh_d  = yh_q;
    btn_d = btn_q;
    if (rx_ack_q) begin
      case (state_q)
        ST_XL:   xl_d  = byte_q;
        ST_XH:   xh_d  = byte_q[0];
        ST_YL:   yl_d  = byte_q;
        ST_YH:   yh_d  = byte_q[0];
        ST_BTN:  btn_d = byte_q[2:0];
        default: xl_d  = xl_q;
      endcase
    end else begin
      xl_d = xl_q;
    end
  end

  // Outputs: APPLY integrates the deltas (screen Y grows downward); center overrides position only.
  always_comb begin
    dx_s = {{(SW-9){xh_q}}, xh_q, xl_q} <<< DELTA_SHIFT;
    dy_s = {{(SW-9){yh_q}}, yh_q, yl_q} <<< DELTA_SHIFT;
    nx_s = $signed({5'd0, pos_x_q}) + dx_s;
    ny_s = $signed({5'd0, pos_y_q}) - dy_s;

    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    buttons_d     = buttons_q;
    btn_press_d   = 3'd0;
    btn_release_d = 3'd0;
    pkt_valid_d   = 1'b0;
    pkt_count_d   = pkt_count_q;
    pkt_error_d   = tmo_s | frame_err_s | sum_err_s;

    if (state_q == ST_APPLY) begin
      pos_x_d       = clamp_pos(nx_s, X_MAX_S);
      pos_y_d       = clamp_pos(ny_s, Y_MAX_S);
      buttons_d     = btn_q;
      btn_press_d   = btn_q & ~buttons_q;
      btn_release_d = ~btn_q & buttons_q;
      pkt_valid_d   = 1'b1;
      pkt_count_d   = pkt_count_q + 16'd1;
    end else begin
      pkt_valid_d = 1'b0;
    end

    if (center) begin
      pos_x_d = X_RST;
      pos_y_d = Y_RST;
    end else begin
      pos_y_d = pos_y_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q        <= 8'd0;
      rx_ack_q      <= 1'b0;
      tmo_q         <= {TMO_W{1'b0}};
      xl_q          <= 8'd0;
      xh_q          <= 1'b0;
      yl_q          <= 8'd0;
      yh_q          <= 1'b0;
      btn_q         <= 3'd0;
      pos_x_q       <= X_RST;
      pos_y_q       <= Y_RST;
      buttons_q     <= 3'd0;
      btn_press_q   <= 3'd0;
      btn_release_q <= 3'd0;
      pkt_valid_q   <= 1'b0;
      pkt_error_q   <= 1'b0;
      pkt_count_q   <= 16'd0;
    end else begin
      byte_q        <= byte_d;
      rx_ack_q      <= rx_ack_d;
      tmo_q         <= tmo_d;
      xl_q          <= xl_d;
      xh_q          <= xh_d;
      yl_q          <= yl_d;
      yh_q          <= yh_d;
      btn_q         <= btn_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      buttons_q     <= buttons_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_error_q   <= pkt_error_d;
      pkt_count_q   <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_uart_mouse_tracker.sv
// Bench for uart_mouse_tracker: directed packet scenarios plus randomized packets against a cursor model.
module tb_uart_mouse_tracker;

  localparam int POS_W   = 11;
  localparam int X_MAX   = 639;
  localparam int Y_MAX   = 479;
  localparam int SHIFT   = 0;
  localparam int TMO_CYC = 200;
`ifdef MOUSE_CHECKSUM_EN
  localparam int NCOR = 3;
`else
  localparam int NCOR = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_avail = 1'b0;
  logic             rx_ack;
  logic             center = 1'b0;
  logic [POS_W-1:0] pos_x, pos_y;
  logic [2:0]       buttons, btn_press, btn_release;
  logic             pkt_valid, pkt_error;
  logic [15:0]      pkt_count;

  uart_mouse_tracker #(
    .FREQ_HZ(1000000), .TIMEOUT_US(TMO_CYC), .SYNC_BYTE(8'hAA), .POS_W(POS_W),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .DELTA_SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .center(center), .pos_x(pos_x), .pos_y(pos_y), .buttons(buttons),
    .btn_press(btn_press), .btn_release(btn_release), .pkt_valid(pkt_valid),
    .pkt_error(pkt_error), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_sent   = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0, ack_cnt = 0;

  // Reference cursor state
  int         mx, my, mcnt;
  logic [2:0] mbtn, mpress, mrel;
  logic [7:0] pq[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid) valid_cnt <= valid_cnt + 1;
      if (pkt_error) err_cnt <= err_cnt + 1;
      if (pkt_valid && pkt_error) both_cnt <= both_cnt + 1;
      if (rx_ack) ack_cnt <= ack_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    rx_data  = b;
    rx_avail = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rx_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    rx_avail = 1'b0;
    n_sent++;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_pq();
    foreach (pq[i]) send_byte(pq[i]);
  endtask

  // corrupt: 0 none, 1 bad X sign byte, 2 reserved button bit, 3 bad checksum
  task automatic build_pkt(input int dx, input int dy, input logic [2:0] b, input int corrupt);
    logic [7:0] xh, yh, bb;
    xh = (dx < 0) ? 8'h01 : 8'h00;
    yh = (dy < 0) ? 8'h01 : 8'h00;
    bb = {5'd0, b};
    if (corrupt == 1) xh = 8'h02;
    if (corrupt == 2) bb[7] = 1'b1;
    pq.delete();
    pq.push_back(8'hAA);
    pq.push_back(dx[7:0]);
    pq.push_back(xh);
    pq.push_back(dy[7:0]);
    pq.push_back(yh);
    pq.push_back(bb);
`ifdef MOUSE_CHECKSUM_EN
    begin
      logic [7:0] cs;
      cs = dx[7:0] ^ xh ^ dy[7:0] ^ yh ^ bb;
      if (corrupt == 3) cs = ~cs;
      pq.push_back(cs);
    end
`endif
  endtask

  task automatic model_apply(input int dx, input int dy, input logic [2:0] b, input bit ctr);
    int nx, ny;
    nx = mx + dx * (2 ** SHIFT);
    ny = my - dy * (2 ** SHIFT);
    if (nx < 0) nx = 0;
    if (nx > X_MAX) nx = X_MAX;
    if (ny < 0) ny = 0;
    if (ny > Y_MAX) ny = Y_MAX;
    if (ctr) begin
      nx = X_MAX / 2;
      ny = Y_MAX / 2;
    end
    mpress = b & ~mbtn;
    mrel   = ~b & mbtn;
    mbtn   = b;
    mx     = nx;
    my     = ny;
    mcnt   = (mcnt + 1) % 65536;
  endtask

  task automatic expect_good(input string tag, input int dx, input int dy, input logic [2:0] b,
                             input bit ctr);
    @(posedge clk); #1;
    check({tag, "_early"}, pkt_valid, 32'd0);
    center = ctr;
    @(posedge clk); #1;
    center = 1'b0;
    model_apply(dx, dy, b, ctr);
    check({tag, "_valid"}, pkt_valid, 32'd1);
    check({tag, "_noerr"}, pkt_error, 32'd0);
    check({tag, "_x"}, pos_x, mx);
    check({tag, "_y"}, pos_y, my);
    check({tag, "_btn"}, buttons, mbtn);
    check({tag, "_press"}, btn_press, mpress);
    check({tag, "_rel"}, btn_release, mrel);
    check({tag, "_cnt"}, pkt_count, mcnt);
    @(posedge clk); #1;
    check({tag, "_vpulse"}, pkt_valid, 32'd0);
    check({tag, "_ppulse"}, btn_press, 32'd0);
  endtask

  task automatic expect_drop(input string tag, input int e0, input int v0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_err"}, err_cnt, e0 + 1);
    check({tag, "_novalid"}, valid_cnt, v0);
    check({tag, "_x"}, pos_x, mx);
    check({tag, "_y"}, pos_y, my);
    check({tag, "_btn"}, buttons, mbtn);
    check({tag, "_cnt"}, pkt_count, mcnt);
  endtask

  initial begin
    int e0, v0, dx, dy, corrupt;
    logic [2:0] b;
    logic [7:0] g;

    mx = X_MAX / 2; my = Y_MAX / 2; mcnt = 0; mbtn = 3'd0; mpress = 3'd0; mrel = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", pos_x, 32'd319);
    check("rst_y", pos_y, 32'd239);
    check("rst_btn", buttons, 32'd0);
    check("rst_valid", pkt_valid, 32'd0);
    check("rst_err", pkt_error, 32'd0);
    check("rst_cnt", pkt_count, 32'd0);
    check("rst_ack", rx_ack, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic packet -> (324,244), left button
    build_pkt(5, -5, 3'b001, 0);
    send_pq();
    expect_good("t1", 5, -5, 3'b001, 1'b0);
    check("t1_abs_x", pos_x, 32'd324);
    check("t1_abs_y", pos_y, 32'd244);

    // 2: clamp at right edge, then at left edge
    for (int i = 0; i < 3; i++) begin
      build_pkt(255, 0, 3'b000, 0);
      send_pq();
      expect_good("t2_right", 255, 0, 3'b000, 1'b0);
    end
    check("t2_xmax", pos_x, 32'd639);
    for (int i = 0; i < 4; i++) begin
      build_pkt(-256, 0, 3'b010, 0);
      send_pq();
      expect_good("t2_left", -256, 0, 3'b010, 1'b0);
    end
    check("t2_xmin", pos_x, 32'd0);

    // 3: partial packet then idle -> one timeout error, then a full packet works
    e0 = err_cnt; v0 = valid_cnt;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h00);
    repeat (TMO_CYC - 50) @(posedge clk);
    #1;
    check("t3_not_yet", err_cnt, e0);
    repeat (70) @(posedge clk);
    #1;
    check("t3_tmo_err", err_cnt, e0 + 1);
    check("t3_novalid", valid_cnt, v0);
    check("t3_x", pos_x, mx);
    check("t3_y", pos_y, my);
    build_pkt(7, 3, 3'b100, 0);
    send_pq();
    expect_good("t3_after", 7, 3, 3'b100, 1'b0);

    // 4: garbage before sync is silent; bad X sign byte drops the packet
    e0 = err_cnt;
    send_byte(8'h12); send_byte(8'h34);
    repeat (3) @(posedge clk);
    #1;
    check("t4_garbage_silent", err_cnt, e0);
    v0 = valid_cnt;
    build_pkt(5, -5, 3'b001, 1);
    send_pq();
    expect_drop("t4_frame", e0, v0);
    build_pkt(-20, 40, 3'b011, 0);
    send_pq();
    expect_good("t4_after", -20, 40, 3'b011, 1'b0);

    // 5: center coincident with APPLY wins for position only
    build_pkt(10, 0, 3'b000, 0);
    send_pq();
    expect_good("t5", 10, 0, 3'b000, 1'b1);
    check("t5_cx", pos_x, 32'd319);
    check("t5_cy", pos_y, 32'd239);

    // Standalone recenter
    build_pkt(100, 100, 3'b000, 0);
    send_pq();
    expect_good("t5b", 100, 100, 3'b000, 1'b0);
    center = 1'b1;
    @(posedge clk); #1;
    center = 1'b0;
    mx = X_MAX / 2; my = Y_MAX / 2;
    check("center_x", pos_x, mx);
    check("center_y", pos_y, my);

`ifdef MOUSE_CHECKSUM_EN
    // 6: checksum accepted, then corrupted
    pq.delete();
    pq = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pq();
    expect_good("t6_ok", 1, 1, 3'b000, 1'b0);
    e0 = err_cnt; v0 = valid_cnt;
    pq[6] = 8'h55;
    send_pq();
    expect_drop("t6_bad", e0, v0);
`endif

    // Randomized packets with occasional garbage, gaps and corruption
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hAA) g = 8'h12;
        send_byte(g);
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      dx = int'($urandom_range(0, 511)) - 256;
      dy = int'($urandom_range(0, 511)) - 256;
      b  = 3'($urandom_range(0, 7));
      corrupt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NCOR)) : 0;
      e0 = err_cnt; v0 = valid_cnt;
      build_pkt(dx, dy, b, corrupt);
      send_pq();
      if (corrupt != 0) expect_drop("rnd_drop", e0, v0);
      else expect_good("rnd", dx, dy, b, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("never_both", both_cnt, 32'd0);
    check("one_ack_per_byte", ack_cnt, n_sent);
    check("final_cnt", pkt_count, mcnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
